// File: rtl/up_drp_pkg.sv
// ============================================================================
// Module   : up_drp_pkg
// Brief    : Shared FSM encoding and defaults for the uP-to-DRP bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package up_drp_pkg;

    localparam int C_ST_WIDTH = 2;

    typedef logic [C_ST_WIDTH-1:0] drp_state_t;

    localparam drp_state_t C_ST_IDLE  = 2'd0;
    localparam drp_state_t C_ST_ISSUE = 2'd1;
    localparam drp_state_t C_ST_WAIT  = 2'd2;
    localparam drp_state_t C_ST_DONE  = 2'd3;

    localparam logic [31:0] C_TIMEOUT_DATA_DEFAULT = 32'hDEAD_DEAD;

endpackage

`default_nettype wire

// File: rtl/ad_sync_bit.sv
// ============================================================================
// Module   : ad_sync_bit
// Brief    : Two-flop synchronizer for a single asynchronous level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad_sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/up_drp_bridge.sv
// ============================================================================
// Module   : up_drp_bridge
// Brief    : Single-outstanding uP register bus to DRP bridge with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_drp_bridge
    import up_drp_pkg::*;
#(
    parameter int          DRP_ADDR_WIDTH = 7,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = C_TIMEOUT_DATA_DEFAULT
) (
    input  logic                      up_clk,
    input  logic                      up_rstn,
    input  logic                      up_drp_sel,
    input  logic                      up_drp_wr,
    input  logic [11:0]               up_drp_addr,
    input  logic [31:0]               up_drp_wdata,
    output logic [31:0]               up_drp_rdata,
    output logic                      up_drp_ready,
    output logic                      up_drp_locked,
    output logic                      drp_en,
    output logic                      drp_we,
    output logic [DRP_ADDR_WIDTH-1:0] drp_addr,
    output logic [15:0]               drp_di,
    input  logic [15:0]               drp_do,
    input  logic                      drp_rdy,
    input  logic                      mmcm_locked,
    output logic                      up_drp_busy,
    output logic                      up_drp_timeout
);

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    drp_state_t r_state;
    drp_state_t w_state_nxt;

    logic [15:0]               r_cnt;
    logic                      r_drp_en;
    logic                      r_drp_we;
    logic [DRP_ADDR_WIDTH-1:0] r_drp_addr;
    logic [15:0]               r_drp_di;
    logic [31:0]               r_rdata;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_timeout;

    logic                      w_accept;
    logic                      w_tmo;
    logic                      w_rdy;
    logic                      w_en_nxt;
    logic                      w_we_nxt;
    logic                      w_ready_nxt;
    logic                      w_busy_nxt;
    logic                      w_timeout_nxt;
    logic [31:0]               w_rdata_nxt;
    logic                      w_unused;

    assign w_accept = (r_state == C_ST_IDLE) && up_drp_sel;
    assign w_rdy    = (r_state == C_ST_WAIT) && drp_rdy;
    assign w_tmo    = (r_state == C_ST_WAIT) && (r_cnt >= c_TMO_LAST);

    // Address/data bits beyond the primitive width are intentionally dropped.
    assign w_unused = ^{up_drp_addr, up_drp_wdata[31:16]};

    // State and all registered outputs
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state    <= C_ST_IDLE;
            r_cnt      <= 16'd0;
            r_drp_en   <= 1'b0;
            r_drp_we   <= 1'b0;
            r_drp_addr <= '0;
            r_drp_di   <= 16'd0;
            r_rdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_drp_en  <= w_en_nxt;
            r_drp_we  <= w_we_nxt;
            r_rdata   <= w_rdata_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_accept) begin
                r_drp_addr <= up_drp_addr[DRP_ADDR_WIDTH-1:0];
                r_drp_di   <= up_drp_wdata[15:0];
            end
            if (r_state == C_ST_ISSUE) begin
                r_cnt <= 16'd0;
            end else if ((r_state == C_ST_WAIT) && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE:  if (up_drp_sel) w_state_nxt = C_ST_ISSUE;
            C_ST_ISSUE: w_state_nxt = C_ST_WAIT;
            C_ST_WAIT:  if (drp_rdy || w_tmo) w_state_nxt = C_ST_DONE;
            C_ST_DONE:  w_state_nxt = C_ST_IDLE;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Next values for the output registers; a ready response beats a timeout.
    always_comb begin
        w_en_nxt      = w_accept;
        w_we_nxt      = w_accept && up_drp_wr;
        w_ready_nxt   = w_rdy || w_tmo;
        w_busy_nxt    = (w_state_nxt != C_ST_IDLE);
        w_rdata_nxt   = r_rdata;
        w_timeout_nxt = r_timeout;
        if (w_accept) begin
            w_timeout_nxt = 1'b0;
        end
        if (w_rdy) begin
            w_rdata_nxt = {16'd0, drp_do};
        end else if (w_tmo) begin
            w_rdata_nxt   = TIMEOUT_DATA;
            w_timeout_nxt = 1'b1;
        end
    end

    ad_sync_bit u_lock_sync (
        .clk   (up_clk),
        .rst_n (up_rstn),
        .i_d   (mmcm_locked),
        .o_q   (up_drp_locked)
    );

    assign drp_en         = r_drp_en;
    assign drp_we         = r_drp_we;
    assign drp_addr       = r_drp_addr;
    assign drp_di         = r_drp_di;
    assign up_drp_rdata   = r_rdata;
    assign up_drp_ready   = r_ready;
    assign up_drp_busy    = r_busy;
    assign up_drp_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_up_drp_bridge.sv
// ============================================================================
// Module   : tb_up_drp_bridge
// Brief    : Scoreboard testbench for up_drp_bridge (TIMEOUT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_drp_bridge;

    localparam int          TMO   = 4;
    localparam logic [31:0] TDATA = 32'hDEAD_DEAD;

    logic        clk;
    logic        rst_n;
    logic        up_drp_sel;
    logic        up_drp_wr;
    logic [11:0] up_drp_addr;
    logic [31:0] up_drp_wdata;
    logic [31:0] up_drp_rdata;
    logic        up_drp_ready;
    logic        up_drp_locked;
    logic        drp_en;
    logic        drp_we;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_rdy;
    logic        mmcm_locked;
    logic        up_drp_busy;
    logic        up_drp_timeout;

    int n_vec    = 0;
    int n_err    = 0;
    int en_cnt   = 0;
    int rdy_cnt  = 0;
    int n_issue  = 0;
    int n_ready  = 0;

    logic [23:0] issue_q[$];
    logic [32:0] resp_q[$];

    up_drp_bridge #(
        .DRP_ADDR_WIDTH (7),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .up_clk         (clk),
        .up_rstn        (rst_n),
        .up_drp_sel     (up_drp_sel),
        .up_drp_wr      (up_drp_wr),
        .up_drp_addr    (up_drp_addr),
        .up_drp_wdata   (up_drp_wdata),
        .up_drp_rdata   (up_drp_rdata),
        .up_drp_ready   (up_drp_ready),
        .up_drp_locked  (up_drp_locked),
        .drp_en         (drp_en),
        .drp_we         (drp_we),
        .drp_addr       (drp_addr),
        .drp_di         (drp_di),
        .drp_do         (drp_do),
        .drp_rdy        (drp_rdy),
        .mmcm_locked    (mmcm_locked),
        .up_drp_busy    (up_drp_busy),
        .up_drp_timeout (up_drp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [60:0] all_outs();
        return {up_drp_rdata, up_drp_ready, up_drp_locked, drp_en, drp_we,
                drp_addr, drp_di, up_drp_busy, up_drp_timeout};
    endfunction

    // Scoreboard: pop expected primitive accesses and responses as they appear
    always @(negedge clk) begin
        if (drp_en) begin
            en_cnt++;
            if (issue_q.size() == 0) chk("spurious_en", 64'd1, 64'd0);
            else chk("issue", {40'd0, drp_we, drp_addr, drp_di}, {40'd0, issue_q.pop_front()});
        end
        if (up_drp_ready) begin
            rdy_cnt++;
            if (resp_q.size() == 0) chk("spurious_rdy", 64'd1, 64'd0);
            else chk("resp", {31'd0, up_drp_timeout, up_drp_rdata}, {31'd0, resp_q.pop_front()});
        end
    end

    // dly = cycles after drp_en at which drp_rdy is pulsed (1..TMO), 0 = never.
    task automatic req(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       input int dly, input logic [15:0] dout, input logic collide);
        logic [32:0] exp_resp;
        issue_q.push_back({wr, addr[6:0], wd[15:0]});
        exp_resp = (dly == 0) ? {1'b1, TDATA} : {1'b0, 16'd0, dout};
        resp_q.push_back(exp_resp);
        n_issue++;
        n_ready++;
        @(posedge clk); #1;
        up_drp_sel = 1'b1; up_drp_wr = wr; up_drp_addr = addr; up_drp_wdata = wd;
        @(posedge clk); #1;
        up_drp_sel = collide;
        up_drp_addr = ~addr;
        up_drp_wdata = ~wd;
        @(negedge clk);
        chk("busy_issue", {63'd0, up_drp_busy}, 64'd1);
        chk("tmo_clr", {63'd0, up_drp_timeout}, 64'd0);
        @(posedge clk); #1;
        up_drp_sel = 1'b0;
        if (dly > 0) begin
            repeat (dly - 1) @(posedge clk);
            #1 drp_rdy = 1'b1; drp_do = dout;
            @(posedge clk); #1 drp_rdy = 1'b0; drp_do = 16'h0;
        end else begin
            repeat (TMO) @(posedge clk);
        end
        @(negedge clk);
        chk("rdy_lat", {63'd0, up_drp_ready}, 64'd1);
        @(negedge clk);
        chk("rdy_pulse", {62'd0, up_drp_ready, up_drp_busy}, 64'd0);
        chk("rdata_hold", {32'd0, up_drp_rdata}, {32'd0, exp_resp[31:0]});
    endtask

    initial begin
        rst_n = 1'b0; up_drp_sel = 1'b0; up_drp_wr = 1'b0; up_drp_addr = 12'h0;
        up_drp_wdata = 32'h0; drp_do = 16'h0; drp_rdy = 1'b0; mmcm_locked = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", {3'd0, all_outs()}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Lock synchronizer latency
        repeat (3) @(posedge clk);
        #1 mmcm_locked = 1'b0;
        @(posedge clk); #1 mmcm_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1 mmcm_locked = 1'b0;
        @(negedge clk); chk("lock_lat0", {63'd0, up_drp_locked}, 64'd1);
        @(negedge clk); chk("lock_lat1", {63'd0, up_drp_locked}, 64'd1);
        @(negedge clk); chk("lock_lat2", {63'd0, up_drp_locked}, 64'd0);
        #1 mmcm_locked = 1'b1;
        repeat (3) @(negedge clk);
        chk("lock_rise", {63'd0, up_drp_locked}, 64'd1);

        req(1'b0, 12'h015, 32'h0, 3, 16'h1234, 1'b0);
        req(1'b1, 12'h008, 32'hABCD_5A5A, 2, 16'h0000, 1'b0);
        req(1'b0, 12'hF95, 32'h0, 1, 16'hFACE, 1'b0);
        req(1'b0, 12'h020, 32'h0, 0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", {63'd0, up_drp_timeout}, 64'd1);
        req(1'b0, 12'h07F, 32'h0, 1, 16'hA5A5, 1'b0);
        req(1'b0, 12'h011, 32'h0, TMO, 16'h5555, 1'b0);
        req(1'b1, 12'h003, 32'h0000_1111, 2, 16'h2222, 1'b1);

        // drp_rdy while idle must be ignored
        @(posedge clk); #1 drp_rdy = 1'b1; drp_do = 16'h9999;
        @(posedge clk); #1 drp_rdy = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_rdy_rdata", {32'd0, up_drp_rdata}, 64'h2222);

        // Reset while waiting for drp_rdy
        issue_q.push_back({1'b0, 7'h44, 16'h0});
        n_issue++;
        @(posedge clk); #1 up_drp_sel = 1'b1; up_drp_wr = 1'b0; up_drp_addr = 12'h044; up_drp_wdata = 32'h0;
        @(posedge clk); #1 up_drp_sel = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk("rst_mid_wait", {3'd0, all_outs()}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_busy", {63'd0, up_drp_busy}, 64'd0);
        req(1'b0, 12'h015, 32'h0, 2, 16'h0BAD, 1'b0);

        repeat (3) @(negedge clk);
        chk("en_count", 64'(en_cnt), 64'(n_issue));
        chk("rdy_count", 64'(rdy_cnt), 64'(n_ready));
        chk("q_empty", 64'(issue_q.size() + resp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
